// File: rtl/qoa_slice_decoder.sv
// rtl/qoa_slice_decoder.sv - QOA slice decoder, bytes in, LMS-predicted PCM out (option macro: QOA_DEC_SEQ_MAC_EN)
module qoa_slice_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lms_load,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        slice_done,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LMS_RX, SLICE_RX, COMPUTE, EMIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [4:0]         idx_q, idx_d;
    logic [63:0]        slice_q, slice_d;
    logic [11:0]        scale_q, scale_d;
    logic               fill_q, fill_d;
    logic signed [15:0] h_q [4];
    logic signed [15:0] h_d [4];
    logic signed [15:0] w_q [4];
    logic signed [15:0] w_d [4];
    logic signed [15:0] dq_q, dq_d;
    logic [15:0]        sample_q, sample_d;

    logic               rx_ready;
    logic               lms_wr;
    logic [3:0]         lms_idx;
    logic [2:0]         res;
    logic [4:0]         mult;
    logic [14:0]        mag;
    logic signed [15:0] dq;
    logic signed [15:0] delta;
    logic signed [33:0] mac_sum;
    logic signed [33:0] pred;
    logic signed [33:0] sum;
    logic [15:0]        clamped;

    function automatic logic [11:0] scale_lut(input logic [3:0] sf);
        case (sf)
            4'd0:    return 12'd1;
            4'd1:    return 12'd7;
            4'd2:    return 12'd21;
            4'd3:    return 12'd45;
            4'd4:    return 12'd84;
            4'd5:    return 12'd138;
            4'd6:    return 12'd211;
            4'd7:    return 12'd304;
            4'd8:    return 12'd421;
            4'd9:    return 12'd562;
            4'd10:   return 12'd731;
            4'd11:   return 12'd928;
            4'd12:   return 12'd1157;
            4'd13:   return 12'd1419;
            4'd14:   return 12'd1715;
            default: return 12'd2048;
        endcase
    endfunction

`ifdef QOA_DEC_SEQ_MAC_EN
    logic [1:0]         ph_q, ph_d;
    logic signed [33:0] acc_q, acc_d;
    logic signed [31:0] prod;

    // One multiplier walks the four taps; ph_q selects the tap
    always_comb begin
        prod    = h_q[ph_q] * w_q[ph_q];
        mac_sum = acc_q + $signed({{2{prod[31]}}, prod});
    end
`else
    logic signed [31:0] prod [4];

    // Four parallel taps summed in a single cycle
    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k] = h_q[k] * w_q[k];
            mac_sum = mac_sum + $signed({{2{prod[k][31]}}, prod[k]});
        end
    end
`endif

    // Dequantise the current residual and form the clamped predicted sample
    always_comb begin
        res = slice_q[59:57];
        case (res[2:1])
            2'd0:    mult = 5'd3;
            2'd1:    mult = 5'd10;
            2'd2:    mult = 5'd18;
            default: mult = 5'd28;
        endcase
        mag   = 15'((17'(scale_q) * 17'(mult) + 17'd2) >> 2);
        dq    = res[0] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        pred  = mac_sum >>> 13;
        sum   = pred + $signed({{18{dq[15]}}, dq});
        if (sum > 34'sd32767)
            clamped = 16'h7fff;
        else if (sum < -34'sd32768)
            clamped = 16'h8000;
        else
            clamped = sum[15:0];
        delta = dq_q >>> 4;
    end

    // Next-state, handshakes and LMS state update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        slice_d  = slice_q;
        scale_d  = scale_q;
        fill_d   = fill_q;
        h_d      = h_q;
        w_d      = w_q;
        dq_d     = dq_q;
        sample_d = sample_q;
`ifdef QOA_DEC_SEQ_MAC_EN
        ph_d     = ph_q;
        acc_d    = acc_q;
`endif
        rx_ready   = 1'b0;
        out_valid  = 1'b0;
        slice_done = 1'b0;
        lms_wr     = 1'b0;
        lms_idx    = cnt_q;
        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (lms_load) begin
                    state_d = LMS_RX;
                    cnt_d   = 4'd0;
                    if (in_valid) begin
                        lms_wr  = 1'b1;
                        lms_idx = 4'd0;
                        cnt_d   = 4'd1;
                    end
                end else if (in_valid) begin
                    slice_d = {slice_q[55:0], in_data};
                    cnt_d   = 4'd1;
                    state_d = SLICE_RX;
                end
            end
            LMS_RX: begin
                rx_ready = 1'b1;
                if (in_valid) begin
                    lms_wr = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15)
                        state_d = IDLE;
                end
            end
            SLICE_RX: begin
                rx_ready = 1'b1;
                if (in_valid) begin
                    slice_d = {slice_q[55:0], in_data};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        idx_d   = 5'd0;
                        fill_d  = 1'b1;
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                // First cycle of a slice registers the scale factor
                if (fill_q) begin
                    scale_d = scale_lut(slice_q[63:60]);
                    fill_d  = 1'b0;
                end
`ifdef QOA_DEC_SEQ_MAC_EN
                else if (ph_q != 2'd3) begin
                    acc_d = mac_sum;
                    ph_d  = ph_q + 2'd1;
                end
`endif
                else begin
                    sample_d = clamped;
                    dq_d     = dq;
                    state_d  = EMIT;
`ifdef QOA_DEC_SEQ_MAC_EN
                    acc_d    = '0;
                    ph_d     = 2'd0;
`endif
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    for (int k = 0; k < 4; k++)
                        w_d[k] = h_q[k][15] ? w_q[k] - delta : w_q[k] + delta;
                    h_d[0]  = h_q[1];
                    h_d[1]  = h_q[2];
                    h_d[2]  = h_q[3];
                    h_d[3]  = sample_q;
                    slice_d = {slice_q[63:60], slice_q[56:0], 3'b000};
                    if (idx_q == 5'd19) begin
                        slice_done = 1'b1;
                        idx_d      = 5'd0;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Byte index j carries value j/2, high byte on even j; h0..h3 then w0..w3
        if (lms_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (lms_idx[2:1] == 2'(k)) begin
                    if (!lms_idx[3]) begin
                        if (!lms_idx[0]) h_d[k][15:8] = in_data;
                        else             h_d[k][7:0]  = in_data;
                    end else begin
                        if (!lms_idx[0]) w_d[k][15:8] = in_data;
                        else             w_d[k][7:0]  = in_data;
                    end
                end
            end
        end
    end

    // State register; reset clears everything including the LMS predictor
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            slice_q  <= '0;
            scale_q  <= '0;
            fill_q   <= 1'b0;
            dq_q     <= '0;
            sample_q <= '0;
            for (int k = 0; k < 4; k++) begin
                h_q[k] <= '0;
                w_q[k] <= '0;
            end
`ifdef QOA_DEC_SEQ_MAC_EN
            ph_q     <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            slice_q  <= slice_d;
            scale_q  <= scale_d;
            fill_q   <= fill_d;
            dq_q     <= dq_d;
            sample_q <= sample_d;
            h_q      <= h_d;
            w_q      <= w_d;
`ifdef QOA_DEC_SEQ_MAC_EN
            ph_q     <= ph_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready   = rx_ready & ~rst;
    assign out_sample = sample_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_qoa_slice_decoder.sv
// tb/tb_qoa_slice_decoder.sv - scoreboard bench for qoa_slice_decoder
`timescale 1ns/1ps
module tb_qoa_slice_decoder;
`ifdef QOA_DEC_SEQ_MAC_EN
    localparam int LAT  = 5;
    localparam int PER  = 5;
    localparam int DONE = 100;
`else
    localparam int LAT  = 2;
    localparam int PER  = 2;
    localparam int DONE = 40;
`endif
    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        lms_load = 1'b0;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        slice_done;
    logic        busy;

    qoa_slice_decoder dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lms_load(lms_load), .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
        .slice_done(slice_done), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   kcyc = 0;
    int   last_hs = 0;
    int   hs_cnt = 0;
    bit   prev_valid = 0;
    bit   timing_on = 0;
    int   rdy_mode = 1;
    int   stall_left = 0;

    int mh[4];
    int mw[4];
    int scale_t[16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    int mtab[4] = '{3, 10, 18, 28};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int wrap16(input int v);
        shortint t;
        t = shortint'(v);
        return int'(t);
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Reference decode of one slice from the current model LMS state
    task automatic model_slice(input logic [63:0] s);
        int     sf, r, mag, dq, smp, delta;
        longint acc, p, t;
        exp_t   e;
        sf = int'(s[63:60]);
        for (int i = 0; i < 20; i++) begin
            r = int'((s >> (57 - 3 * i)) & 64'h7);
            acc = 0;
            for (int k = 0; k < 4; k++) acc += longint'(mh[k]) * longint'(mw[k]);
            p   = floor_div(acc, 8192);
            mag = (scale_t[sf] * mtab[r / 2] + 2) / 4;
            dq  = (r % 2 == 1) ? -mag : mag;
            t   = p + dq;
            smp = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : int'(t));
            e.s = 16'(smp);
            e.last = (i == 19);
            exp_q.push_back(e);
            delta = int'(floor_div(dq, 16));
            for (int k = 0; k < 4; k++) mw[k] = wrap16(mw[k] + ((mh[k] < 0) ? -delta : delta));
            mh[0] = mh[1]; mh[1] = mh[2]; mh[2] = mh[3]; mh[3] = smp;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations on each output handshake
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (out_valid) begin
                chk("in_ready_low_while_emit", 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 32'(out_valid), 32'd0);
                end else begin
                    chk("sample", 32'(out_sample), 32'(exp_q[0].s));
                    if (timing_on && !prev_valid && hs_cnt == 0)
                        chk("first_valid_latency", 32'(cyc - kcyc), 32'(LAT));
                    if (out_ready) begin
                        chk("slice_done", 32'(slice_done), 32'(exp_q[0].last));
                        if (timing_on && hs_cnt > 0)
                            chk("sample_period", 32'(cyc - last_hs), 32'(PER));
                        if (timing_on && exp_q[0].last)
                            chk("slice_done_time", 32'(cyc - kcyc), 32'(DONE));
                        last_hs = cyc;
                        hs_cnt = exp_q[0].last ? 0 : hs_cnt + 1;
                        void'(exp_q.pop_front());
                    end else begin
                        chk("slice_done_stalled", 32'(slice_done), 32'd0);
                    end
                end
            end else if (busy) begin
                chk("slice_done_no_valid", 32'(slice_done), 32'd0);
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 0;
        end
    end

    // out_ready policy: 0 low, 1 high, 2 random, 3 stall 10 cycles on sample 5
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (hs_cnt == 5 && stall_left > 0) begin
                    out_ready = 1'b0;
                    if (out_valid) stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ld);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        lms_load = ld;
        while (!acc && n < TMO) begin
            @(negedge clk);
            acc = in_ready;
            step();
            lms_load = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("in_handshake_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < TMO);
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        step();
    endtask

    task automatic pulse_load();
        lms_load = 1'b1;
        step();
        lms_load = 1'b0;
    endtask

    task automatic load_lms(input int h[4], input int w[4], input bit same);
        logic [15:0] v;
        wait_idle();
        if (!same) pulse_load();
        for (int j = 0; j < 8; j++) begin
            v = (j < 4) ? 16'(h[j]) : 16'(w[j - 4]);
            send_byte(v[15:8], same && j == 0);
            send_byte(v[7:0], 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            mh[k] = wrap16(h[k]);
            mw[k] = wrap16(w[k]);
        end
    endtask

    task automatic send_slice(input logic [63:0] s, input bit gaps, input bit mid_ld);
        model_slice(s);
        for (int j = 0; j < 8; j++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            send_byte(s[63 - 8 * j -: 8], mid_ld && j == 3);
        end
        kcyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        lms_load = 1'b0;
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        hs_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            mh[k] = 0;
            mw[k] = 0;
        end
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_slice_done", 32'(slice_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
    endtask

    task automatic rand_lms(output int h[4], output int w[4]);
        for (int k = 0; k < 4; k++) begin
            h[k] = int'($urandom_range(0, 65535)) - 32768;
            w[k] = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    initial begin
        int  ha[4];
        int  wa[4];
        int  n;
        bit  gaps;
        for (int k = 0; k < 4; k++) begin
            mh[k] = 0;
            mw[k] = 0;
        end
        step();
        do_reset();

        // All-zero slice from zero state
        timing_on = 1;
        rdy_mode = 1;
        send_slice(64'h0, 1'b0, 1'b0);

        // Clamping load (lms_load together with first byte), then a follow-up slice
        ha = '{0, 0, 0, 30000};
        wa = '{0, 0, 0, 8192};
        load_lms(ha, wa, 1'b1);
        send_slice(64'hFC00_0000_0000_0000, 1'b0, 1'b0);
        send_slice(64'h0, 1'b0, 1'b0);

        // Zero weights, residuals 1,3,5,7; lms_load inside a slice and during COMPUTE is ignored
        ha = '{0, 0, 0, 0};
        wa = '{0, 0, 0, 0};
        load_lms(ha, wa, 1'b0);
        send_slice(64'h02EF_0000_0000_0000, 1'b0, 1'b1);
        pulse_load();
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);

        // Back-pressure: 10-cycle stall on sample 5
        wait_idle();
        rand_lms(ha, wa);
        load_lms(ha, wa, 1'b0);
        timing_on = 0;
        stall_left = 10;
        rdy_mode = 3;
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);
        wait_idle();
        rdy_mode = 1;

        // Reset after 4 slice bytes
        rand_lms(ha, wa);
        load_lms(ha, wa, 1'b0);
        for (int j = 0; j < 4; j++) send_byte(8'($urandom), 1'b0);
        do_reset();
        timing_on = 1;
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);

        // Randomised groups of back-to-back slices
        for (int g = 0; g < 6; g++) begin
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                rand_lms(ha, wa);
                load_lms(ha, wa, 1'($urandom_range(0, 1)));
            end
            rdy_mode = (g % 2 == 0) ? 1 : 2;
            timing_on = (rdy_mode == 1);
            gaps = 1'($urandom_range(0, 1));
            for (int s = 0; s < 4; s++) send_slice({$urandom, $urandom}, gaps, 1'b0);
        end

        // Reset while a sample is pending drops it and clears LMS state
        wait_idle();
        rand_lms(ha, wa);
        load_lms(ha, wa, 1'b0);
        timing_on = 0;
        rdy_mode = 0;
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < TMO);
        chk("pending_sample_seen", 32'(out_valid), 32'd1);
        step();
        do_reset();
        rdy_mode = 1;
        timing_on = 1;
        send_slice({$urandom, $urandom}, 1'b0, 1'b0);

        wait_idle();
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
